// File: rtl/tdo_gen.sv
// -----------------------------------------------------------------------------
// tdo_gen : serial drive engine for the JTAG-style executor.
//
// Builds TCK from the prescaler clock (clk_tdo_gen) and shifts drive bytes,
// fetched from the RAM sequencer over byte_req/byte_ack, out on tdi_gen one
// bit per TCK period. It also publishes tck_gen, dmux_sel, state and tdo_en
// for the downstream TDI read/compare stage.
//
// Build option:
//   TDO_GEN_MSB_FIRST_EN  defined   -> bits leave MSB first (shreg[7-dmux_sel])
//                         undefined -> bits leave LSB first (shreg[dmux_sel])
//
// Ports:
//   master_clk   in   system clock, rising edge
//   reset_cpu    in   asynchronous reset, active high
//   clk_tdo_gen  in   prescaler output, asynchronous to master_clk
//   start        in   one-cycle pulse, begins a shift (IDLE only)
//   abort        in   synchronous abort, wins over start
//   bit_len      in   number of bits to shift, latched at start
//   byte_in      in   drive byte, valid with byte_ack
//   byte_ack     in   one-cycle byte valid pulse
//   byte_req     out  request for the next drive byte
//   tck_gen      out  test clock
//   tdi_gen      out  serial drive bit
//   tdo_en       out  high in SETUP/HIGH
//   dmux_sel     out  bit index within the current byte
//   state        out  FSM state code
//   busy         out  state != IDLE
//   done         out  one-cycle pulse when a shift completes
// -----------------------------------------------------------------------------
module tdo_gen #(
  parameter int unsigned LEN_W = 24
) (
  input  logic             master_clk,
  input  logic             reset_cpu,
  input  logic             clk_tdo_gen,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] bit_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_ack,
  output logic             byte_req,
  output logic             tck_gen,
  output logic             tdi_gen,
  output logic             tdo_en,
  output logic [2:0]       dmux_sel,
  output logic [3:0]       state,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] S_IDLE  = 4'h0;
  localparam logic [3:0] S_FETCH = 4'h1;
  localparam logic [3:0] S_SETUP = 4'h2;
  localparam logic [3:0] S_HIGH  = 4'h3;
  localparam logic [3:0] S_DONE  = 4'h4;

  // Synchronizer, edge detect and registered tick
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_tick;

  // FSM and datapath registers
  logic [3:0]       r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [7:0]       r_shreg;
  logic [2:0]       r_dmux;
  logic             r_tdi;
  logic             r_tck;
  logic             r_tdo_en;
  logic             r_req;
  logic             r_busy;
  logic             r_done;

  // Next-state values
  logic [3:0]       w_state_nxt;
  logic [LEN_W-1:0] w_remaining_nxt;
  logic [7:0]       w_shreg_nxt;
  logic [2:0]       w_dmux_nxt;
  logic [2:0]       w_dmux_inc;
  logic             w_tdi_nxt;

  // Map a bit index within the byte onto the shift register position
  function automatic logic [2:0] f_bit_pos(input logic [2:0] sel);
`ifdef TDO_GEN_MSB_FIRST_EN
    return 3'd7 - sel;
`else
    return sel;
`endif
  endfunction

  // Bring clk_tdo_gen into master_clk domain and make a one-cycle tick per rising edge
  always_ff @(posedge master_clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= clk_tdo_gen;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  assign w_dmux_inc = r_dmux + 3'd1;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_shreg_nxt     = r_shreg;
    w_dmux_nxt      = r_dmux;
    w_tdi_nxt       = r_tdi;

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            w_remaining_nxt = bit_len;
            w_state_nxt     = (bit_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          // Ticks here are dropped, which stretches the TCK low phase
          if (byte_ack) begin
            w_shreg_nxt = byte_in;
            w_dmux_nxt  = 3'd0;
            w_tdi_nxt   = byte_in[f_bit_pos(3'd0)];
            w_state_nxt = S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_tick) begin
            w_state_nxt = S_HIGH;
          end
        end
        S_HIGH: begin
          // TCK falling edge: count the bit and pick where to go next
          if (r_tick) begin
            w_remaining_nxt = r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              w_state_nxt = S_DONE;
            end else if (r_dmux == 3'd7) begin
              w_state_nxt = S_FETCH;
            end else begin
              w_dmux_nxt  = w_dmux_inc;
              w_tdi_nxt   = r_shreg[f_bit_pos(w_dmux_inc)];
              w_state_nxt = S_SETUP;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // they line up with the state register
  always_ff @(posedge master_clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_shreg     <= 8'h00;
      r_dmux      <= 3'd0;
      r_tdi       <= 1'b0;
      r_tck       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_shreg     <= w_shreg_nxt;
      r_dmux      <= w_dmux_nxt;
      r_tdi       <= w_tdi_nxt;
      r_tck       <= (w_state_nxt == S_HIGH);
      r_tdo_en    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_HIGH);
      r_req       <= (w_state_nxt == S_FETCH);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign byte_req = r_req;
  assign tck_gen  = r_tck;
  assign tdi_gen  = r_tdi;
  assign tdo_en   = r_tdo_en;
  assign dmux_sel = r_dmux;
  assign state    = r_state;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_tdo_gen.sv
// -----------------------------------------------------------------------------
// tb_tdo_gen : scoreboard bench for tdo_gen.
// Stimulus pushes the expected bit stream (computed from byte data and bit
// count) into a queue; a monitor pops one entry per TCK rising edge.
// -----------------------------------------------------------------------------
module tb_tdo_gen;

  localparam int unsigned LEN_W = 24;

  logic             master_clk  = 1'b0;
  logic             reset_cpu   = 1'b1;
  logic             clk_tdo_gen = 1'b0;
  logic             start       = 1'b0;
  logic             abort       = 1'b0;
  logic [LEN_W-1:0] bit_len     = '0;
  logic [7:0]       byte_in     = 8'h00;
  logic             byte_ack    = 1'b0;
  logic             byte_req;
  logic             tck_gen;
  logic             tdi_gen;
  logic             tdo_en;
  logic [2:0]       dmux_sel;
  logic [3:0]       state;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
  } exp_t;

  exp_t       q_exp[$];
  logic [7:0] q_bytes[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         ack_delay = 0;
  int         ack_wait = 0;
  int         done_seen = 0;
  int         req_seen = 0;
  int         rise_seen = 0;
  logic       tck_prev = 1'b0;
  logic       req_prev = 1'b0;

  tdo_gen #(.LEN_W(LEN_W)) dut (
    .master_clk (master_clk),
    .reset_cpu  (reset_cpu),
    .clk_tdo_gen(clk_tdo_gen),
    .start      (start),
    .abort      (abort),
    .bit_len    (bit_len),
    .byte_in    (byte_in),
    .byte_ack   (byte_ack),
    .byte_req   (byte_req),
    .tck_gen    (tck_gen),
    .tdi_gen    (tdi_gen),
    .tdo_en     (tdo_en),
    .dmux_sel   (dmux_sel),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  always #5 master_clk = ~master_clk;

  // Prescaler clock, deliberately off the master_clk rising-edge grid
  initial begin
    #2;
    forever #36 clk_tdo_gen = ~clk_tdo_gen;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
  endtask

  // RAM sequencer model: answers byte_req after ack_delay cycles
  always @(negedge master_clk) begin
    if (reset_cpu) begin
      byte_ack = 1'b0;
      ack_wait = 0;
    end else if (byte_ack) begin
      byte_ack = 1'b0;
    end else if (byte_req) begin
      if (ack_wait < ack_delay) begin
        ack_wait++;
      end else begin
        ack_wait = 0;
        byte_in  = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'h00;
        byte_ack = 1'b1;
      end
    end
  end

  // Monitor: one expected bit per TCK rising edge, plus event counters
  always @(negedge master_clk) begin
    if (!reset_cpu) begin
      if (tck_gen && !tck_prev) begin
        rise_seen++;
        if (q_exp.size() == 0) begin
          fail_now("extra_tck", rise_seen, 0);
        end else begin
          mon_e = q_exp.pop_front();
          check("tdi_bit", 32'(tdi_gen), 32'(mon_e.b));
          check("dmux_sel", 32'(dmux_sel), 32'(mon_e.sel));
          check("tdo_en_hi", 32'(tdo_en), 32'h1);
        end
      end
      if (state == 4'h1) check("fetch_tck_low", 32'(tck_gen), 32'h0);
      if (done) done_seen++;
      if (byte_req && !req_prev) req_seen++;
    end
    tck_prev = tck_gen;
    req_prev = byte_req;
  end

  // Reference model: expected bit i is bit (i mod 8) of byte i/8, in shift order
  task automatic load_model(input int len, input logic [63:0] data);
    int idx;
    exp_t e;
    q_bytes.delete();
    q_exp.delete();
    for (int k = 0; k < (len + 7) / 8; k++) q_bytes.push_back(data[k*8 +: 8]);
    for (int i = 0; i < len; i++) begin
`ifdef TDO_GEN_MSB_FIRST_EN
      idx = 7 - (i % 8);
`else
      idx = i % 8;
`endif
      e.b   = data[(i / 8) * 8 + idx];
      e.sel = 3'(i % 8);
      q_exp.push_back(e);
    end
  endtask

  task automatic run_shift(input int len, input logic [63:0] data, input int dly, input bit extra_start);
    int d0;
    int r0;
    int budget;
    int waited;
    load_model(len, data);
    ack_delay = dly;
    d0 = done_seen;
    r0 = req_seen;
    @(negedge master_clk);
    start   = 1'b1;
    bit_len = LEN_W'(len);
    @(negedge master_clk);
    start = 1'b0;
    if (len == 0) begin
      check("zero_len_done", 32'(done), 32'h1);
      check("zero_len_req", 32'(byte_req), 32'h0);
    end else begin
      check("start_to_req", 32'(byte_req), 32'h1);
    end
    budget = len * 20 + ((len + 7) / 8) * (dly + 20) + 50;
    waited = 0;
    while (busy && waited < budget) begin
      if (extra_start && waited == 30) begin
        start   = 1'b1;
        bit_len = LEN_W'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge master_clk);
      waited++;
    end
    start = 1'b0;
    if (busy) fail_now("shift_timeout", waited, budget);
    check("bits_left", 32'(q_exp.size()), 32'h0);
    check("done_count", 32'(done_seen - d0), 32'h1);
    check("req_count", 32'(req_seen - r0), 32'((len + 7) / 8));
    q_exp.delete();
  endtask

  initial begin
    int d0;
    int r0;
    int w;

    repeat (3) @(negedge master_clk);
    check("rst_tck", 32'(tck_gen), 32'h0);
    check("rst_tdi", 32'(tdi_gen), 32'h0);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);
    check("rst_req", 32'(byte_req), 32'h0);
    check("rst_dmux", 32'(dmux_sel), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset_cpu = 1'b0;
    repeat (2) @(negedge master_clk);

    // Directed shifts
    run_shift(3, 64'hA5, 0, 1'b0);
    run_shift(10, 64'h02FF, 35, 1'b0);
    run_shift(0, 64'h0, 0, 1'b0);
    run_shift(8, 64'h81, 2, 1'b1);

    // start and abort together in IDLE: abort wins
    @(negedge master_clk);
    start   = 1'b1;
    abort   = 1'b1;
    bit_len = LEN_W'(5);
    @(negedge master_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_state", 32'(state), 32'h0);
    check("start_abort_req", 32'(byte_req), 32'h0);

    // Abort during HIGH of bit 4
    load_model(16, 64'h3C5A);
    ack_delay = 1;
    d0 = done_seen;
    r0 = rise_seen;
    @(negedge master_clk);
    start   = 1'b1;
    bit_len = LEN_W'(16);
    @(negedge master_clk);
    start = 1'b0;
    w = 0;
    while ((rise_seen - r0) < 4 && w < 400) begin
      @(negedge master_clk);
      w++;
    end
    if ((rise_seen - r0) < 4) fail_now("abort_wait_timeout", rise_seen - r0, 4);
    check("abort_pre_state", 32'(state), 32'h3);
    abort = 1'b1;
    @(negedge master_clk);
    abort = 1'b0;
    check("abort_tck", 32'(tck_gen), 32'h0);
    check("abort_state", 32'(state), 32'h0);
    check("abort_tdo_en", 32'(tdo_en), 32'h0);
    check("abort_req", 32'(byte_req), 32'h0);
    q_exp.delete();
    q_bytes.delete();
    repeat (20) @(negedge master_clk);
    check("abort_no_done", 32'(done_seen - d0), 32'h0);
    run_shift(5, 64'h16, 0, 1'b0);

    // Asynchronous reset in the middle of a HIGH phase
    load_model(16, 64'hC3E7);
    ack_delay = 0;
    d0 = done_seen;
    @(negedge master_clk);
    start   = 1'b1;
    bit_len = LEN_W'(16);
    @(negedge master_clk);
    start = 1'b0;
    w = 0;
    while (state != 4'h3 && w < 200) begin
      @(negedge master_clk);
      w++;
    end
    if (state != 4'h3) fail_now("rst_wait_timeout", int'(state), 3);
    #2;
    reset_cpu = 1'b1;
    #1;
    check("midrst_tck", 32'(tck_gen), 32'h0);
    check("midrst_tdi", 32'(tdi_gen), 32'h0);
    check("midrst_tdo_en", 32'(tdo_en), 32'h0);
    check("midrst_req", 32'(byte_req), 32'h0);
    check("midrst_dmux", 32'(dmux_sel), 32'h0);
    check("midrst_state", 32'(state), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    q_exp.delete();
    q_bytes.delete();
    @(negedge master_clk);
    reset_cpu = 1'b0;
    repeat (3) @(negedge master_clk);
    check("postrst_state", 32'(state), 32'h0);
    check("postrst_no_done", 32'(done_seen - d0), 32'h0);

    // Randomized shifts
    for (int n = 0; n < 6; n++) begin
      run_shift(int'($urandom_range(1, 64)), {$urandom, $urandom}, int'($urandom_range(0, 6)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
